// File: rtl/uart_prog_loader.sv
// UART program loader: receives an 8N1 length-prefixed image and writes it as
// little-endian DATA_W-bit words through a simple memory write port.
module uart_prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 347,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned TIMEOUT_CLKS = 34700
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic              rx_i,
  input  logic              rearm_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              busy_o,
  output logic              ready_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic [ADDR_W:0]   word_cnt_o
);

  localparam int unsigned CntW     = $clog2(CLKS_PER_BIT);
  localparam int unsigned Half     = CLKS_PER_BIT / 2;
  localparam int unsigned Bytes    = DATA_W / 8;
  localparam int unsigned MaxWords = 2 ** ADDR_W;
  localparam int unsigned WcW      = ADDR_W + 1;
  localparam int unsigned TmoW     = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS + 1) : 1;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_st_e;
  typedef enum logic [2:0] {LdHdr0, LdHdr1, LdData, LdDone, LdErr} ld_st_e;

  // Synchronizer plus one history flop for falling-edge detection.
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  rx_st_e          rx_st_q;
  logic [CntW-1:0] bit_cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      rx_shift_q;
  logic            byte_valid_q;
  logic            frame_err_q;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rx_st_q      <= RxIdle;
      bit_cnt_q    <= '0;
      bit_idx_q    <= '0;
      rx_shift_q   <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      unique case (rx_st_q)
        RxIdle: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_st_q   <= RxStart;
            bit_cnt_q <= '0;
          end
        end
        RxStart: begin
          if (bit_cnt_q == CntW'(Half - 1)) begin
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            rx_st_q   <= rx_sync_q ? RxIdle : RxData;
          end else begin
            bit_cnt_q <= bit_cnt_q + CntW'(1);
          end
        end
        RxData: begin
          if (bit_cnt_q == CntW'(CLKS_PER_BIT - 1)) begin
            bit_cnt_q  <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            if (bit_idx_q == 3'd7) rx_st_q <= RxStop;
            else bit_idx_q <= bit_idx_q + 3'd1;
          end else begin
            bit_cnt_q <= bit_cnt_q + CntW'(1);
          end
        end
        RxStop: begin
          if (bit_cnt_q == CntW'(CLKS_PER_BIT - 1)) begin
            bit_cnt_q    <= '0;
            byte_valid_q <= rx_sync_q;
            frame_err_q  <= !rx_sync_q;
            rx_st_q      <= RxIdle;
          end else begin
            bit_cnt_q <= bit_cnt_q + CntW'(1);
          end
        end
        default: rx_st_q <= RxIdle;
      endcase
    end
  end

  ld_st_e            ld_st_q;
  logic [15:0]       len_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   word_cnt_q;
  logic [DATA_W-1:0] wbuf_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [3:0]        byte_idx_q;
  logic [TmoW-1:0]   tmo_cnt_q;
  logic              mem_we_q, busy_q, ready_q, err_q;
  logic [1:0]        err_code_q;

  logic              counting, tmo_hit, bad_len, last_word, fail;
  logic [1:0]        fail_code;
  logic [15:0]       hdr_len;
  logic [DATA_W-1:0] word_next;

  assign counting  = (ld_st_q == LdHdr1) || (ld_st_q == LdData);
  assign tmo_hit   = (TIMEOUT_CLKS != 0) && counting && !byte_valid_q &&
                     (tmo_cnt_q == TmoW'(TIMEOUT_CLKS));
  assign hdr_len   = {rx_shift_q, len_q[7:0]};
  assign bad_len   = (hdr_len == 16'd0) || (32'(hdr_len) > MaxWords);
  assign last_word = (32'(word_cnt_q) + 32'd1) == 32'(len_q);
  assign word_next = wbuf_q | (DATA_W'(rx_shift_q) << (8 * byte_idx_q));

  // The first failing event wins; ERR is only left through rearm or reset.
  always_comb begin
    fail      = 1'b0;
    fail_code = 2'd0;
    if (ld_st_q inside {LdHdr0, LdHdr1, LdData}) begin
      if (frame_err_q) begin
        fail      = 1'b1;
        fail_code = 2'd1;
      end else if ((ld_st_q == LdHdr1) && byte_valid_q && bad_len) begin
        fail      = 1'b1;
        fail_code = 2'd2;
      end else if (tmo_hit) begin
        fail      = 1'b1;
        fail_code = 2'd3;
      end
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      tmo_cnt_q <= '0;
    end else if (byte_valid_q || !counting) begin
      tmo_cnt_q <= '0;
    end else if (tmo_cnt_q != TmoW'(TIMEOUT_CLKS)) begin
      tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      ld_st_q     <= LdHdr0;
      len_q       <= '0;
      addr_q      <= '0;
      word_cnt_q  <= '0;
      wbuf_q      <= '0;
      mem_wdata_q <= '0;
      byte_idx_q  <= '0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      mem_we_q <= 1'b0;
      if (fail) begin
        ld_st_q    <= LdErr;
        err_q      <= 1'b1;
        err_code_q <= fail_code;
        busy_q     <= 1'b0;
        wbuf_q     <= '0;
        byte_idx_q <= '0;
      end else begin
        unique case (ld_st_q)
          LdHdr0: begin
            if (byte_valid_q) begin
              len_q[7:0] <= rx_shift_q;
              busy_q     <= 1'b1;
              ld_st_q    <= LdHdr1;
            end
          end
          LdHdr1: begin
            if (byte_valid_q) begin
              len_q[15:8] <= rx_shift_q;
              ld_st_q     <= LdData;
            end
          end
          LdData: begin
            if (byte_valid_q) begin
              if (byte_idx_q == 4'(Bytes - 1)) begin
                mem_we_q    <= 1'b1;
                mem_wdata_q <= word_next;
                wbuf_q      <= '0;
                byte_idx_q  <= '0;
              end else begin
                wbuf_q     <= word_next;
                byte_idx_q <= byte_idx_q + 4'd1;
              end
            end else if (mem_we_q) begin
              // Address advances after the strobe; it wraps on a full-size image.
              addr_q     <= addr_q + ADDR_W'(1);
              word_cnt_q <= word_cnt_q + WcW'(1);
              if (last_word) begin
                ld_st_q <= LdDone;
                ready_q <= 1'b1;
                busy_q  <= 1'b0;
              end
            end
          end
          LdDone, LdErr: begin
            if (rearm_i) begin
              ld_st_q    <= LdHdr0;
              ready_q    <= 1'b0;
              err_q      <= 1'b0;
              err_code_q <= 2'd0;
              word_cnt_q <= '0;
              addr_q     <= '0;
              wbuf_q     <= '0;
              byte_idx_q <= '0;
            end
          end
          default: ld_st_q <= LdHdr0;
        endcase
      end
    end
  end

  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = busy_q;
  assign ready_o     = ready_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;
  assign word_cnt_o  = word_cnt_q;

endmodule
